// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit multiplexed seven-segment scanner with frame-latched digit codes
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [4:0] bcd3,
    input  logic [4:0] bcd2,
    input  logic [4:0] bcd1,
    input  logic [4:0] bcd0,
    input  logic       si,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] dwell_cnt;
    logic [1:0]    digit_idx;
    logic          capture_pending;
    logic [4:0]    sh_bcd3, sh_bcd2, sh_bcd1, sh_bcd0;
    logic          sh_si;
    logic          tick;
    logic [4:0]    code_sel;
    logic          blank3, blank2, blank1, blank_sel;
    logic [6:0]    seg_next;

    function automatic logic [6:0] decode_glyph(input logic [4:0] code);
        logic [6:0] glyph;
        case (code)
            5'd0:    glyph = 7'h40;
            5'd1:    glyph = 7'h79;
            5'd2:    glyph = 7'h24;
            5'd3:    glyph = 7'h30;
            5'd4:    glyph = 7'h19;
            5'd5:    glyph = 7'h12;
            5'd6:    glyph = 7'h02;
            5'd7:    glyph = 7'h78;
            5'd8:    glyph = 7'h00;
            5'd9:    glyph = 7'h10;
            5'h1F:   glyph = 7'h77;
            default: glyph = 7'h7F;
        endcase
        return glyph;
    endfunction

    assign tick = (dwell_cnt == DWELL_LAST);

    always_comb begin
        blank3 = 1'b0;
        blank2 = 1'b0;
        blank1 = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank3 = (sh_bcd3 == 5'd0);
        blank2 = blank3 && (sh_bcd2 == 5'd0);
        blank1 = blank2 && (sh_bcd1 == 5'd0);
`endif
        case (digit_idx)
            2'd0:    begin code_sel = sh_bcd0; blank_sel = 1'b0;   end
            2'd1:    begin code_sel = sh_bcd1; blank_sel = blank1; end
            2'd2:    begin code_sel = sh_bcd2; blank_sel = blank2; end
            default: begin code_sel = sh_bcd3; blank_sel = blank3; end
        endcase
        seg_next = blank_sel ? 7'h7F : decode_glyph(code_sel);
    end

    // The first cycle out of reset only latches the frame; scanning starts on the next edge
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            dwell_cnt       <= '0;
            digit_idx       <= 2'd0;
            capture_pending <= 1'b1;
            sh_bcd3         <= 5'd0;
            sh_bcd2         <= 5'd0;
            sh_bcd1         <= 5'd0;
            sh_bcd0         <= 5'd0;
            sh_si           <= 1'b0;
            an              <= 4'hF;
            seg             <= 7'h7F;
            dp              <= 1'b1;
        end else if (capture_pending) begin
            capture_pending <= 1'b0;
            sh_bcd3         <= bcd3;
            sh_bcd2         <= bcd2;
            sh_bcd1         <= bcd1;
            sh_bcd0         <= bcd0;
            sh_si           <= si;
            an              <= 4'hF;
            seg             <= 7'h7F;
            dp              <= 1'b1;
        end else begin
            dwell_cnt <= tick ? '0 : dwell_cnt + CW'(1);
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (tick && digit_idx == 2'd3) begin
                sh_bcd3 <= bcd3;
                sh_bcd2 <= bcd2;
                sh_bcd1 <= bcd1;
                sh_bcd0 <= bcd0;
                sh_si   <= si;
            end
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_next;
            dp  <= ~((digit_idx == 2'd0) && sh_si);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner at REFRESH_DIV=4
module tb_seven_seg_scanner;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] bcd3 = 5'd1, bcd2 = 5'd2, bcd1 = 5'd3, bcd0 = 5'd4;
    logic       si = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests_run = 0;
    int tests_failed = 0;

    seven_seg_scanner #(.REFRESH_DIV(4)) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bcd3   (bcd3),
        .bcd2   (bcd2),
        .bcd1   (bcd1),
        .bcd0   (bcd0),
        .si     (si),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic check_blank(input string tag);
        check({tag, ".an"}, 32'(an), 32'hF);
        check({tag, ".seg"}, 32'(seg), 32'h7F);
        check({tag, ".dp"}, 32'(dp), 32'h1);
    endtask

    task automatic show_digit(input string tag, input int d, input logic [6:0] exp_seg, input logic exp_dp, input int cycles);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << d);
        for (int c = 0; c < cycles; c++) begin
            step();
            check($sformatf("%s.d%0d.c%0d.an", tag, d, c), 32'(an), 32'(exp_an));
            check($sformatf("%s.d%0d.c%0d.seg", tag, d, c), 32'(seg), 32'(exp_seg));
            check($sformatf("%s.d%0d.c%0d.dp", tag, d, c), 32'(dp), 32'(exp_dp));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            step();
            check_blank($sformatf("rst%0d", i));
        end
        reset = 1'b0;
        step();
        check_blank("capture");

        // frame 0: 1,2,3,4; inputs change while digit 1 is being shown
        show_digit("f0", 0, 7'h19, 1'b1, 4);
        show_digit("f0", 1, 7'h30, 1'b1, 4);
        bcd1 = 5'd5;
        bcd0 = 5'h1F;
        show_digit("f0", 2, 7'h24, 1'b1, 4);
        show_digit("f0", 3, 7'h79, 1'b1, 4);

        // frame 1: underscore and 5 appear; next codes staged
        bcd3 = 5'd9; bcd2 = 5'd9; bcd1 = 5'd9; bcd0 = 5'd9; si = 1'b1;
        show_digit("f1", 0, 7'h77, 1'b1, 4);
        show_digit("f1", 1, 7'h12, 1'b1, 4);
        show_digit("f1", 2, 7'h24, 1'b1, 4);
        show_digit("f1", 3, 7'h79, 1'b1, 4);

        // frame 2: all nines with saturation flag
        bcd3 = 5'd0; bcd2 = 5'd0; bcd1 = 5'd7; bcd0 = 5'd0; si = 1'b0;
        show_digit("f2", 0, 7'h10, 1'b0, 4);
        show_digit("f2", 1, 7'h10, 1'b1, 4);
        show_digit("f2", 2, 7'h10, 1'b1, 4);
        show_digit("f2", 3, 7'h10, 1'b1, 4);

        // frame 3: 0,0,7,0 leading-zero behaviour
        show_digit("f3", 0, 7'h40, 1'b1, 4);
        show_digit("f3", 1, 7'h78, 1'b1, 4);
`ifdef LEADING_ZERO_BLANK_EN
        show_digit("f3", 2, 7'h7F, 1'b1, 4);
        show_digit("f3", 3, 7'h7F, 1'b1, 4);
`else
        show_digit("f3", 2, 7'h40, 1'b1, 4);
        show_digit("f3", 3, 7'h40, 1'b1, 4);
`endif

        // frame 4: reset pulse while digit 2 is mid-dwell
        show_digit("f4", 0, 7'h40, 1'b1, 4);
        show_digit("f4", 1, 7'h78, 1'b1, 4);
`ifdef LEADING_ZERO_BLANK_EN
        show_digit("f4", 2, 7'h7F, 1'b1, 2);
`else
        show_digit("f4", 2, 7'h40, 1'b1, 2);
`endif
        reset = 1'b1;
        bcd3 = 5'd10; bcd2 = 5'd30; bcd1 = 5'd4; bcd0 = 5'd3; si = 1'b1;
        step();
        check_blank("midrst");
        reset = 1'b0;
        step();
        check_blank("midrst_capture");

        // fresh frame: blank codes 10 and 30, digit 0 first with decimal point
        show_digit("f5", 0, 7'h30, 1'b0, 4);
        show_digit("f5", 1, 7'h19, 1'b1, 4);
        show_digit("f5", 2, 7'h7F, 1'b1, 4);
        show_digit("f5", 3, 7'h7F, 1'b1, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
